// File: rtl/mem_stage.sv
// Memory-access pipeline stage: word loads/stores against an internal array
// with a fixed multi-cycle latency, producing the registered MEM/WB bundle.
module mem_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int LAT    = 2
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              in_valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              mem_to_reg,
    input  logic              reg_write,
    input  logic [4:0]        rd,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] store_data,
    output logic              stall,
    output logic              out_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic [4:0]        wb_rd,
    output logic              wb_reg_write,
    output logic              err
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state;
    logic [3:0]          cnt;
    logic [ADDR_W-1:0]   cap_idx;
    logic [DATA_W-1:0]   cap_data;
    logic [DATA_W-1:0]   cap_alu;
    logic [4:0]          cap_rd;
    logic                cap_reg_write;
    logic                cap_to_reg;
    logic                cap_write;

    logic [DATA_W-1:0]   mem [0:(1<<ADDR_W)-1];

    logic is_mem;
    logic bad;
    logic complete;

    assign stall    = (state == BUSY);
    assign is_mem   = mem_read | mem_write;
    assign bad      = (mem_read & mem_write) | (alu_result[1:0] != 2'b00);
    assign complete = (state == BUSY) && (cnt == 4'd1);

    // Storage is deliberately not reset; state going IDLE on reset kills the write.
    always_ff @(posedge Clk) begin
        if (complete && cap_write) begin
            mem[cap_idx] <= cap_data;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state         <= IDLE;
            cnt           <= '0;
            out_valid     <= 1'b0;
            wb_data       <= '0;
            wb_rd         <= '0;
            wb_reg_write  <= 1'b0;
            err           <= 1'b0;
            cap_idx       <= '0;
            cap_data      <= '0;
            cap_alu       <= '0;
            cap_rd        <= '0;
            cap_reg_write <= 1'b0;
            cap_to_reg    <= 1'b0;
            cap_write     <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            err       <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (!is_mem) begin
                            out_valid    <= 1'b1;
                            wb_data      <= alu_result;
                            wb_rd        <= rd;
                            wb_reg_write <= reg_write;
                        end else if (bad) begin
                            out_valid    <= 1'b1;
                            err          <= 1'b1;
                            wb_data      <= alu_result;
                            wb_rd        <= rd;
                            wb_reg_write <= 1'b0;
                        end else begin
                            state         <= BUSY;
                            cnt           <= 4'(LAT);
                            cap_idx       <= alu_result[ADDR_W+1:2];
                            cap_data      <= store_data;
                            cap_alu       <= alu_result;
                            cap_rd        <= rd;
                            cap_reg_write <= reg_write;
                            cap_to_reg    <= mem_to_reg;
                            cap_write     <= mem_write;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (complete) begin
                        state        <= IDLE;
                        out_valid    <= 1'b1;
                        wb_rd        <= cap_rd;
                        wb_reg_write <= cap_reg_write;
                        // Stores never read, keeping the array single-ported.
                        if (cap_to_reg && !cap_write) begin
                            wb_data <= mem[cap_idx];
                        end else begin
                            wb_data <= cap_alu;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with LAT=2, ADDR_W=8.
module tb_mem_stage;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int LAT    = 2;

    logic              Clk;
    logic              Reset_n;
    logic              in_valid;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              reg_write;
    logic [4:0]        rd;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] store_data;
    logic              stall;
    logic              out_valid;
    logic [DATA_W-1:0] wb_data;
    logic [4:0]        wb_rd;
    logic              wb_reg_write;
    logic              err;

    int checks;
    int failures;

    mem_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LAT(LAT)) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .in_valid(in_valid),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_to_reg(mem_to_reg),
        .reg_write(reg_write),
        .rd(rd),
        .alu_result(alu_result),
        .store_data(store_data),
        .stall(stall),
        .out_valid(out_valid),
        .wb_data(wb_data),
        .wb_rd(wb_rd),
        .wb_reg_write(wb_reg_write),
        .err(err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_idle();
        in_valid   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        rd         = '0;
        alu_result = '0;
        store_data = '0;
    endtask

    // Issues one instruction, keeps junk on the inputs while stalled, and
    // returns what the stage produced once stall drops.
    task automatic access(input logic r_op, input logic w_op, input logic [31:0] addr,
                          input logic [31:0] data, input logic [4:0] dst,
                          input logic to_reg, input logic rw,
                          output int edges, output int stalls,
                          output logic [31:0] o_data, output logic [4:0] o_rd,
                          output logic o_rw, output logic o_err, output logic o_ov);
        in_valid   = 1'b1;
        mem_read   = r_op;
        mem_write  = w_op;
        mem_to_reg = to_reg;
        reg_write  = rw;
        rd         = dst;
        alu_result = addr;
        store_data = data;
        tick();
        edges  = 1;
        stalls = 0;
        mem_read   = 1'b0;
        mem_write  = 1'b1;
        alu_result = 32'hFFFF_FFF0;
        store_data = 32'h0BAD_0BAD;
        rd         = 5'd31;
        reg_write  = 1'b1;
        while (stall && edges < 40) begin
            stalls++;
            tick();
            edges++;
        end
        o_data = wb_data;
        o_rd   = wb_rd;
        o_rw   = wb_reg_write;
        o_err  = err;
        o_ov   = out_valid;
        drive_idle();
    endtask

    task automatic test_reset();
        drive_idle();
        Reset_n = 1'b1;
        #3;
        Reset_n = 1'b0;
        #1;
        checks++;
        if ({stall, out_valid, wb_data, wb_rd, wb_reg_write, err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got stall=%b ov=%b data=%h rd=%0d rw=%b err=%b, want all 0",
                     stall, out_valid, wb_data, wb_rd, wb_reg_write, err);
        end
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        tick();
        tick();
        checks++;
        if (stall !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got stall=%b ov=%b, want 0 0", stall, out_valid);
        end
    endtask

    task automatic test_passthrough();
        int e, s;
        logic [31:0] d;
        logic [4:0] r;
        logic w, er, ov;
        access(1'b0, 1'b0, 32'h1234, 32'h0, 5'd7, 1'b0, 1'b1, e, s, d, r, w, er, ov);
        checks++;
        if (ov !== 1'b1 || d !== 32'h1234 || r !== 5'd7 || w !== 1'b1 || er !== 1'b0 || s != 0 || e != 1) begin
            failures++;
            $display("FAIL passthrough: got ov=%b data=%h rd=%0d rw=%b err=%b stalls=%0d edges=%0d, want 1 1234 7 1 0 0 1",
                     ov, d, r, w, er, s, e);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || wb_data !== 32'h1234) begin
            failures++;
            $display("FAIL passthrough_hold: got ov=%b data=%h, want 0 1234", out_valid, wb_data);
        end
    endtask

    task automatic test_store_load();
        int e, s;
        logic [31:0] d;
        logic [4:0] r;
        logic w, er, ov;
        access(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 5'd5, 1'b0, 1'b0, e, s, d, r, w, er, ov);
        checks++;
        if (s != LAT || e != LAT + 1 || ov !== 1'b1 || w !== 1'b0 || er !== 1'b0) begin
            failures++;
            $display("FAIL store_timing: got stalls=%0d edges=%0d ov=%b rw=%b err=%b, want %0d %0d 1 0 0",
                     s, e, ov, w, er, LAT, LAT + 1);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL store_pulse: got ov=%b, want 0", out_valid);
        end
        access(1'b1, 1'b0, 32'h10, 32'h0, 5'd3, 1'b1, 1'b1, e, s, d, r, w, er, ov);
        checks++;
        if (d !== 32'hDEAD_BEEF || r !== 5'd3 || w !== 1'b1 || ov !== 1'b1 || e != LAT + 1) begin
            failures++;
            $display("FAIL load_data: got data=%h rd=%0d rw=%b ov=%b edges=%0d, want deadbeef 3 1 1 %0d",
                     d, r, w, ov, e, LAT + 1);
        end
        access(1'b1, 1'b0, 32'h10, 32'h0, 5'd4, 1'b0, 1'b1, e, s, d, r, w, er, ov);
        checks++;
        if (d !== 32'h10 || r !== 5'd4) begin
            failures++;
            $display("FAIL load_no_to_reg: got data=%h rd=%0d, want 00000010 4", d, r);
        end
    endtask

    task automatic test_alias();
        int e, s;
        logic [31:0] d;
        logic [4:0] r;
        logic w, er, ov;
        access(1'b0, 1'b1, 32'h400, 32'hA5, 5'd0, 1'b0, 1'b0, e, s, d, r, w, er, ov);
        access(1'b1, 1'b0, 32'h000, 32'h0, 5'd6, 1'b1, 1'b1, e, s, d, r, w, er, ov);
        checks++;
        if (d !== 32'hA5) begin
            failures++;
            $display("FAIL alias: got data=%h, want 000000a5", d);
        end
    endtask

    task automatic test_errors();
        int e, s;
        logic [31:0] d;
        logic [4:0] r;
        logic w, er, ov;
        access(1'b0, 1'b1, 32'h20, 32'h1111_2222, 5'd0, 1'b0, 1'b0, e, s, d, r, w, er, ov);
        access(1'b1, 1'b0, 32'h13, 32'h0, 5'd8, 1'b1, 1'b1, e, s, d, r, w, er, ov);
        checks++;
        if (ov !== 1'b1 || er !== 1'b1 || w !== 1'b0 || s != 0) begin
            failures++;
            $display("FAIL misaligned: got ov=%b err=%b rw=%b stalls=%0d, want 1 1 0 0", ov, er, w, s);
        end
        tick();
        checks++;
        if (err !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL err_pulse: got err=%b ov=%b, want 0 0", err, out_valid);
        end
        access(1'b1, 1'b1, 32'h20, 32'h0000_0BAD, 5'd9, 1'b1, 1'b1, e, s, d, r, w, er, ov);
        checks++;
        if (ov !== 1'b1 || er !== 1'b1 || w !== 1'b0 || s != 0) begin
            failures++;
            $display("FAIL rw_conflict: got ov=%b err=%b rw=%b stalls=%0d, want 1 1 0 0", ov, er, w, s);
        end
        access(1'b1, 1'b0, 32'h20, 32'h0, 5'd10, 1'b1, 1'b1, e, s, d, r, w, er, ov);
        checks++;
        if (d !== 32'h1111_2222 || er !== 1'b0) begin
            failures++;
            $display("FAIL conflict_no_write: got data=%h err=%b, want 11112222 0", d, er);
        end
    endtask

    task automatic test_reset_busy();
        int e, s;
        logic [31:0] d;
        logic [4:0] r;
        logic w, er, ov;
        access(1'b0, 1'b1, 32'h8, 32'h77, 5'd0, 1'b0, 1'b0, e, s, d, r, w, er, ov);
        in_valid   = 1'b1;
        mem_write  = 1'b1;
        alu_result = 32'h8;
        store_data = 32'h55;
        tick();
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL busy_entry: got stall=%b, want 1", stall);
        end
        drive_idle();
        Reset_n = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy: got stall=%b ov=%b, want 0 0", stall, out_valid);
        end
        #3;
        Reset_n = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (stall !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy_idle: got stall=%b ov=%b, want 0 0", stall, out_valid);
        end
        access(1'b1, 1'b0, 32'h8, 32'h0, 5'd2, 1'b1, 1'b1, e, s, d, r, w, er, ov);
        checks++;
        if (d !== 32'h77) begin
            failures++;
            $display("FAIL abandoned_store: got data=%h, want 00000077", d);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        in_valid   = 1'b1;
        mem_write  = 1'b1;
        alu_result = 32'h30;
        store_data = 32'hCAFE_F00D;
        tick();
        drive_idle();
        n = 0;
        while (stall && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n != LAT || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL b2b_store: got stall_cycles=%0d ov=%b, want %0d 1", n, out_valid, LAT);
        end
        in_valid   = 1'b1;
        mem_read   = 1'b1;
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        rd         = 5'd9;
        alu_result = 32'h30;
        tick();
        drive_idle();
        checks++;
        if (stall !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept: got stall=%b ov=%b, want 1 0", stall, out_valid);
        end
        n = 0;
        while (stall && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (out_valid !== 1'b1 || wb_data !== 32'hCAFE_F00D || wb_rd !== 5'd9 || wb_reg_write !== 1'b1) begin
            failures++;
            $display("FAIL b2b_load: got ov=%b data=%h rd=%0d rw=%b, want 1 cafef00d 9 1",
                     out_valid, wb_data, wb_rd, wb_reg_write);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_passthrough();
        test_store_load();
        test_alias();
        test_errors();
        test_reset_busy();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Stall never coexists with an error pulse; err only rides on out_valid.
    always @(negedge Clk) begin
        if (Reset_n && err === 1'b1 && out_valid !== 1'b1) begin
            failures++;
            $display("FAIL err_without_valid: got err=%b ov=%b, want ov=1", err, out_valid);
        end
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the pipelined datapath. It sits directly downstream of the EX/MEM pipeline register and consumes its decoded fields.
- Performs word loads and stores against an internal data memory with a fixed multi-cycle latency. Asserts a stall back to the pipeline while busy.
- Produces the registered write-back bundle for the MEM/WB stage.

Parameters:
- DATA_W, 32, data and address width.
- ADDR_W, 8, word-index width; memory depth is 2**ADDR_W words.
- LAT, 2, memory access latency in cycles; legal range 1..15.

Ports:
- Clk  in  1  clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  EX/MEM slot holds a valid instruction.
- mem_read  in  1  instruction is a load.
- mem_write  in  1  instruction is a store.
- mem_to_reg  in  1  write-back selects load data, not ALU result.
- reg_write  in  1  instruction writes the register file.
- rd  in  5  destination register.
- alu_result  in  DATA_W  ALU output; doubles as byte address for loads/stores.
- store_data  in  DATA_W  store data.
- stall  out  1  hold EX/MEM and earlier stages this cycle.
- out_valid  out  1  write-back bundle valid; one-cycle pulse per instruction.
- wb_data  out  DATA_W  write-back value.
- wb_rd  out  5  write-back destination.
- wb_reg_write  out  1  write-back enable.
- err  out  1  one-cycle pulse: misaligned address or read+write conflict.

Behaviour:
- Clock and reset: one clock, Clk; reset Reset_n is asynchronous, active-low.
- Reset values: state IDLE, latency counter 0, stall 0, out_valid 0, wb_data 0, wb_rd 0, wb_reg_write 0, err 0. Memory contents are not cleared by reset.
- Reset asserted mid-access abandons the access; a pending store is not committed.
- States: IDLE and BUSY. stall equals (state==BUSY) and is decoded from registered state, with no combinational path from the inputs.
- Word index is alu_result[ADDR_W+1:2]. Higher address bits are ignored, so addresses alias modulo depth.
- IDLE, in_valid=0: out_valid=0 next cycle. Other outputs hold.
- IDLE, in_valid=1, no memory op:
  - Next cycle out_valid=1, wb_data=alu_result, wb_rd=rd, wb_reg_write=reg_write.
  - No stall is raised.
- IDLE, in_valid=1, exactly one of mem_read/mem_write, alu_result[1:0]==0:
  - Capture index, store_data, rd, reg_write and mem_to_reg.
  - Go to BUSY with counter=LAT. out_valid=0 next cycle.
  - stall is 0 in the accepting cycle, so upstream advances normally.
- BUSY:
  - stall=1 and out_valid=0. Inputs are ignored; upstream holds them.
  - Counter decrements each edge.
  - On the edge where the counter reaches 1, the access completes:
    - a store writes memory;
    - a load reads the captured index;
    - the state returns to IDLE.
  - Next cycle out_valid=1 and wb_rd/wb_reg_write come from the captured request.
  - wb_data is load data if mem_to_reg=1, otherwise the captured alu_result.
- Timing: a memory op accepted in cycle t keeps stall high for cycles t+1..t+LAT and pulses out_valid in cycle t+LAT+1. stall is low in t+LAT+1, so a new request may be accepted in that same cycle.
- Load after store to the same word returns the stored data.
- Misaligned address (alu_result[1:0]!=0) with a memory op: no access and no stall. Next cycle out_valid=1, wb_reg_write=0, err=1.
- mem_read and mem_write both set: same handling as misaligned (no access, wb_reg_write=0, err=1).
- err is only ever asserted together with out_valid.
- Synthesis: the memory is a single-port array, one read or one write per access.

Test Plan:
- Reset: assert Reset_n=0 at time 3 (asynchronous) -> all outputs 0 immediately. Release -> stall stays 0 with in_valid=0.
- ALU passthrough, alu_result=0x1234, rd=7, reg_write=1 -> next cycle out_valid=1, wb_data=0x1234, wb_rd=7, wb_reg_write=1, stall never high.
- Store then load, LAT=2:
  - Store 0xDEADBEEF to address 0x10 -> stall high exactly 2 cycles, out_valid pulse with wb_reg_write=0.
  - Load 0x10 with rd=3, mem_to_reg=1 -> wb_data=0xDEADBEEF, wb_rd=3, out_valid 3 cycles after acceptance.
- Aliasing, ADDR_W=8: store 0xA5 to address 0x400, then load address 0x000 -> 0xA5.
- Misaligned load at 0x13, then read+write both set at 0x20 -> err pulse each time, wb_reg_write=0, stall 0, memory word at 0x20 unchanged.
- Reset during BUSY: start store of 0x55 to 0x8, drop Reset_n in the first BUSY cycle -> state IDLE, stall 0. A later load of 0x8 returns its pre-store value.
